// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of one pipelined slave.
// Grants per cyc cycle and throttles each grant to MAX_OUTSTANDING unacked strobes.
module wb_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 3
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic                  m0_wb_cyc_i,
    input  logic                  m0_wb_stb_i,
    input  logic                  m0_wb_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_wb_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_wb_dat_i,
    output logic [DATA_WIDTH-1:0] m0_wb_dat_o,
    output logic                  m0_wb_stall_o,
    output logic                  m0_wb_ack_o,

    input  logic                  m1_wb_cyc_i,
    input  logic                  m1_wb_stb_i,
    input  logic                  m1_wb_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_wb_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_wb_dat_i,
    output logic [DATA_WIDTH-1:0] m1_wb_dat_o,
    output logic                  m1_wb_stall_o,
    output logic                  m1_wb_ack_o,

    output logic                  s_wb_cyc_o,
    output logic                  s_wb_stb_o,
    output logic                  s_wb_we_o,
    output logic [ADDR_WIDTH-1:0] s_wb_adr_o,
    output logic [DATA_WIDTH-1:0] s_wb_dat_o,
    input  logic [DATA_WIDTH-1:0] s_wb_dat_i,
    input  logic                  s_wb_stall_i,
    input  logic                  s_wb_ack_i
);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [2:0] pending_q, pending_d;
    logic       full;
    logic       accept;

    assign full   = (pending_q == 3'(MAX_OUTSTANDING));
    assign accept = s_wb_stb_o & ~s_wb_stall_i;

    assign m0_wb_dat_o = s_wb_dat_i;
    assign m1_wb_dat_o = s_wb_dat_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        pending_d = pending_q;
        // Accept and ack in the same cycle leave the count alone, even at zero.
        if (accept && !s_wb_ack_i) begin
            pending_d = pending_q + 3'd1;
        end else if (!accept && s_wb_ack_i && pending_q != 3'd0) begin
            pending_d = pending_q - 3'd1;
        end
        unique case (state_q)
            StIdle: begin
                pending_d = '0;
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    state_d = last_q ? StGrant0 : StGrant1;
                end else if (m0_wb_cyc_i) begin
                    state_d = StGrant0;
                end else if (m1_wb_cyc_i) begin
                    state_d = StGrant1;
                end
            end
            StGrant0: begin
                if (!m0_wb_cyc_i) begin
                    last_d    = 1'b0;
                    pending_d = '0;
                    state_d   = m1_wb_cyc_i ? StGrant1 : StIdle;
                end
            end
            StGrant1: begin
                if (!m1_wb_cyc_i) begin
                    last_d    = 1'b1;
                    pending_d = '0;
                    state_d   = m0_wb_cyc_i ? StGrant0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_wb_cyc_o    = 1'b0;
        s_wb_stb_o    = 1'b0;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        m0_wb_stall_o = 1'b1;
        m1_wb_stall_o = 1'b1;
        m0_wb_ack_o   = 1'b0;
        m1_wb_ack_o   = 1'b0;
        unique case (state_q)
            StGrant0: begin
                s_wb_cyc_o    = m0_wb_cyc_i;
                s_wb_stb_o    = m0_wb_cyc_i & m0_wb_stb_i & ~full;
                m0_wb_stall_o = s_wb_stall_i | full;
                m0_wb_ack_o   = s_wb_ack_i;
            end
            StGrant1: begin
                s_wb_cyc_o    = m1_wb_cyc_i;
                s_wb_stb_o    = m1_wb_cyc_i & m1_wb_stb_i & ~full;
                s_wb_we_o     = m1_wb_we_i;
                s_wb_adr_o    = m1_wb_adr_i;
                s_wb_dat_o    = m1_wb_dat_i;
                m1_wb_stall_o = s_wb_stall_i | full;
                m1_wb_ack_o   = s_wb_ack_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed corner sequences,
// then random traffic against an owner/last/pending reference model.
module tb_wb_arbiter;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int MAXO = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic          m0_stall, m1_stall, m0_ack, m1_ack;
    logic          s_cyc, s_stb, s_we, s_stall, s_ack;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
        .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_dat_o(m0_dat_o),
        .m0_wb_stall_o(m0_stall), .m0_wb_ack_o(m0_ack),
        .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
        .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_dat_o(m1_dat_o),
        .m1_wb_stall_o(m1_stall), .m1_wb_ack_o(m1_ack),
        .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
        .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat_o), .s_wb_dat_i(s_dat_i),
        .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus (-1 none), who was served last, unacked count.
    int own  = -1;
    int last = 1;
    int pend = 0;
    bit exp_sstb;

    // Slave model: acks each accepted strobe a fixed number of cycles later.
    bit auto_slv  = 1'b0;
    bit extra_ack = 1'b0;
    int ack_delay = 5;
    int cnum      = 0;
    int ackq[$];

    typedef struct {
        bit c0, s0, c1, s1, sst, sak;
        bit e_scyc, e_sstb, e_st0, e_st1, e_ak0, e_ak1;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0;
        s_stall = 0; s_ack = 0; s_dat_i = '0; extra_ack = 0;
    endtask

    task automatic model_reset();
        own = -1; last = 1; pend = 0; cnum = 0;
        ackq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        auto_slv = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_model();
        logic [1:0]    cyc, stb, we, e_stall, e_ack;
        logic [AW-1:0] adr[2];
        logic [DW-1:0] dat[2];
        logic          e_scyc, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        bit            full;
        cyc = {m1_cyc, m0_cyc}; stb = {m1_stb, m0_stb}; we = {m1_we, m0_we};
        adr[0] = m0_adr; adr[1] = m1_adr; dat[0] = m0_dat; dat[1] = m1_dat;
        e_scyc = 0; exp_sstb = 0; e_we = m0_we; e_adr = m0_adr; e_dat = m0_dat;
        e_stall = 2'b11; e_ack = 2'b00;
        if (own >= 0) begin
            full         = (pend == MAXO);
            e_scyc       = cyc[own];
            exp_sstb     = cyc[own] && stb[own] && !full;
            e_we         = we[own];
            e_adr        = adr[own];
            e_dat        = dat[own];
            e_stall[own] = s_stall || full;
            e_ack[own]   = s_ack;
        end
        chk("model_s_cyc", 64'(s_cyc), 64'(e_scyc));
        chk("model_s_stb", 64'(s_stb), 64'(exp_sstb));
        chk("model_s_we", 64'(s_we), 64'(e_we));
        chk("model_s_adr", 64'(s_adr), 64'(e_adr));
        chk("model_s_dat", 64'(s_dat_o), 64'(e_dat));
        chk("model_m0_stall", 64'(m0_stall), 64'(e_stall[0]));
        chk("model_m1_stall", 64'(m1_stall), 64'(e_stall[1]));
        chk("model_m0_ack", 64'(m0_ack), 64'(e_ack[0]));
        chk("model_m1_ack", 64'(m1_ack), 64'(e_ack[1]));
        chk("model_m0_rdat", 64'(m0_dat_o), 64'(s_dat_i));
        chk("model_m1_rdat", 64'(m1_dat_o), 64'(s_dat_i));
    endtask

    task automatic model_step(input bit acc);
        bit cyc[2];
        cyc[0] = m0_cyc; cyc[1] = m1_cyc;
        if (own < 0) begin
            if (cyc[0] && cyc[1]) own = (last == 1) ? 0 : 1;
            else if (cyc[0]) own = 0;
            else if (cyc[1]) own = 1;
        end else if (!cyc[own]) begin
            last = own;
            pend = 0;
            own  = cyc[1-own] ? 1 - own : -1;
        end else if (acc && !s_ack) begin
            pend++;
        end else if (!acc && s_ack && pend > 0) begin
            pend--;
        end
    endtask

    task automatic settle();
        if (auto_slv) s_ack = (ackq.size() > 0 && ackq[0] == cnum) || extra_ack;
        #4;
        check_model();
    endtask

    task automatic advance();
        bit acc;
        acc = exp_sstb && !s_stall;
        if (auto_slv) begin
            if (ackq.size() > 0 && ackq[0] == cnum) void'(ackq.pop_front());
            if (acc) ackq.push_back(cnum + ack_delay);
        end
        model_step(acc);
        @(posedge clk); #1;
        cnum++;
    endtask

    task automatic set_m(input int idx, input bit cyc, input bit stb);
        if (idx == 0) begin m0_cyc = cyc; m0_stb = stb; end
        else begin m1_cyc = cyc; m1_stb = stb; end
    endtask

    initial begin
        int acc_n;
        int g;
        //            c0 s0 c1 s1 st ak   cyc stb st0 st1 ak0 ak1
        tbl[0]  = '{1, 0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 0, 1,  1, 0, 0, 1, 1, 0};
        tbl[4]  = '{0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 1, 1, 0, 0,  1, 1, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 0, 0, 1,  1, 0, 1, 0, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
        tbl[8]  = '{1, 0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0};
        tbl[9]  = '{1, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        tbl[11] = '{1, 0, 1, 1, 1, 0,  1, 1, 1, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
        tbl[13] = '{1, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        tbl[15] = '{1, 0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0};
        tbl[16] = '{1, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 0};

        rst = 1'b1;
        clear_inputs();
        #2;
        chk("reset_s_cyc", 64'(s_cyc), 64'd0);
        chk("reset_s_stb", 64'(s_stb), 64'd0);
        chk("reset_stalls", 64'({m0_stall, m1_stall}), 64'd3);
        chk("reset_acks", 64'({m0_ack, m1_ack}), 64'd0);
        do_reset();

        // Tie-break and handover vectors, one per cycle from reset.
        for (int i = 0; i < 19; i++) begin
            m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0; m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1;
            s_stall = tbl[i].sst; s_ack = tbl[i].sak;
            #4;
            chk($sformatf("vec%0d_s_cyc", i), 64'(s_cyc), 64'(tbl[i].e_scyc));
            chk($sformatf("vec%0d_s_stb", i), 64'(s_stb), 64'(tbl[i].e_sstb));
            chk($sformatf("vec%0d_m0_stall", i), 64'(m0_stall), 64'(tbl[i].e_st0));
            chk($sformatf("vec%0d_m1_stall", i), 64'(m1_stall), 64'(tbl[i].e_st1));
            chk($sformatf("vec%0d_m0_ack", i), 64'(m0_ack), 64'(tbl[i].e_ak0));
            chk($sformatf("vec%0d_m1_ack", i), 64'(m1_ack), 64'(tbl[i].e_ak1));
            @(posedge clk); #1;
        end

        // Single master write of 0xA5.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = '0; m0_dat = 32'h0000_00A5;
        settle();
        chk("single_idle_cyc", 64'(s_cyc), 64'd0);
        chk("single_m1_stall0", 64'(m1_stall), 64'd1);
        advance();
        settle();
        chk("single_cyc", 64'(s_cyc), 64'd1);
        chk("single_stb", 64'(s_stb), 64'd1);
        chk("single_dat", 64'(s_dat_o), 64'h0000_00A5);
        chk("single_m1_stall1", 64'(m1_stall), 64'd1);
        advance();
        m0_stb = 0; s_ack = 1; s_dat_i = 32'h1234_5678;
        settle();
        chk("single_ack", 64'(m0_ack), 64'd1);
        chk("single_m1_stall2", 64'(m1_stall), 64'd1);
        advance();
        s_ack = 0;
        settle();
        chk("single_ack_low", 64'(m0_ack), 64'd0);
        advance();
        m0_cyc = 0;
        settle();
        advance();

        // Round-robin with both masters always wanting the bus.
        do_reset();
        m0_cyc = 1; m1_cyc = 1;
        settle();
        advance();
        for (int k = 0; k < 6; k++) begin
            set_m(k % 2, 1, 1);
            m0_dat = k; m1_dat = k + 100;
            settle();
            g = !m0_stall ? 0 : (!m1_stall ? 1 : -1);
            chk($sformatf("rr_grant%0d", k), 64'(g), 64'(k % 2));
            chk($sformatf("rr_cyc%0d", k), 64'(s_cyc), 64'd1);
            advance();
            set_m(k % 2, 1, 0); s_ack = 1;
            settle();
            advance();
            s_ack = 0;
            set_m(k % 2, 0, 0);
            settle();
            chk($sformatf("rr_gap%0d", k), 64'(s_cyc), 64'd0);
            advance();
            set_m(k % 2, 1, 0);
        end

        // Outstanding limit with a never-stalling slave that acks 5 cycles later.
        do_reset();
        auto_slv = 1; ack_delay = 5; acc_n = 0;
        m0_cyc = 1; m0_stb = 1;
        for (int c = 0; c < 15; c++) begin
            if (acc_n >= 5) m0_stb = 0;
            settle();
            if (c >= 4 && c <= 6) chk($sformatf("limit_stall_c%0d", c), 64'(m0_stall), 64'd1);
            if (c == 7) begin
                chk("limit_accepted_before_ack", 64'(acc_n), 64'd3);
                chk("limit_4th_stb", 64'(s_stb), 64'd1);
                chk("limit_4th_stall", 64'(m0_stall), 64'd0);
            end
            if (c == 8) chk("limit_acc_ack_hold", 64'(m0_stall), 64'd0);
            if (s_stb && !s_stall) acc_n++;
            advance();
        end
        chk("limit_total", 64'(acc_n), 64'd5);
        extra_ack = 1;
        settle();
        chk("zero_ack_pass", 64'(m0_ack), 64'd1);
        advance();
        extra_ack = 0;
        m0_stb = 1;
        for (int j = 0; j < 4; j++) begin
            settle();
            if (j == 3) chk("zero_ack_no_wrap", 64'(m0_stall), 64'd1);
            advance();
        end

        // Async reset while master 1 owns the bus with two strobes unacked.
        do_reset();
        m1_cyc = 1;
        settle();
        advance();
        m1_stb = 1;
        settle(); advance();
        settle(); advance();
        m1_stb = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_s_cyc", 64'(s_cyc), 64'd0);
        chk("arst_s_stb", 64'(s_stb), 64'd0);
        chk("arst_m0_stall", 64'(m0_stall), 64'd1);
        chk("arst_m1_stall", 64'(m1_stall), 64'd1);
        clear_inputs();
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
        m0_cyc = 1; m1_cyc = 1;
        settle();
        advance();
        settle();
        chk("arst_tie_m0", 64'(m0_stall), 64'd0);
        chk("arst_tie_m1", 64'(m1_stall), 64'd1);
        advance();

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5) == 0) m0_cyc = !m0_cyc;
            if ($urandom_range(5) == 0) m1_cyc = !m1_cyc;
            m0_stb = m0_cyc && $urandom_range(1) == 1;
            m1_stb = m1_cyc && $urandom_range(1) == 1;
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_adr = AW'($urandom); m1_adr = AW'($urandom);
            m0_dat = $urandom; m1_dat = $urandom; s_dat_i = $urandom;
            s_stall = $urandom_range(3) == 0;
            s_ack = $urandom_range(2) == 0;
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
